// File: rtl/pixel_frame_src.sv
// rtl/pixel_frame_src.sv - raster test-pattern pixel source with sof/eol/eof framing
module pixel_frame_src #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic        clk_in,
    input  logic        rstn,
    input  logic        start,
    input  logic        stop,
    input  logic        cont,
    input  logic [1:0]  pattern,
    input  logic [7:0]  seed,
    output logic [7:0]  pixel_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        busy,
    output logic [15:0] frames_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    // Working width for pattern arithmetic: at least 8 bits so ramps and checker bits exist.
    localparam int XW = (CW > 8) ? CW : 8;
    localparam int YW = (RW > 8) ? RW : 8;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  col, col_nx;
    logic [RW-1:0]  row, row_nx;
    logic [7:0]     lfsr, lfsr_nx;
    logic [1:0]     pat_r, pat_nx;
    logic           stop_pend, stop_pend_nx;

    logic [7:0]     pixel_nx;
    logic           valid_nx, sof_nx, eol_nx, eof_nx, busy_nx;
    logic [15:0]    frames_nx;

    logic           beat;
    logic           frame_start;
    logic [7:0]     seed_eff;
    logic [XW-1:0]  col_x;
    logic [YW-1:0]  row_x;

    // Next-state logic; registered outputs are computed from the next position so they
    // line up with col/row/lfsr in the following cycle.
    always_comb begin
        state_nx     = state;
        col_nx       = col;
        row_nx       = row;
        lfsr_nx      = lfsr;
        pat_nx       = pat_r;
        stop_pend_nx = stop_pend;
        pixel_nx     = pixel_out;
        valid_nx     = valid_out;
        sof_nx       = sof;
        eol_nx       = eol;
        eof_nx       = eof;
        busy_nx      = busy;
        frames_nx    = frames_done;
        frame_start  = 1'b0;
        beat         = valid_out && ready_in;
        seed_eff     = (seed == 8'h00) ? 8'h01 : seed;
        col_x        = '0;
        row_x        = '0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx    = S_RUN;
                    frame_start = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_nx = 1'b1;
                end
                if (beat) begin
                    lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    if (eof) begin
                        frames_nx = frames_done + 16'd1;
                        if (cont && !stop_pend && !stop) begin
                            frame_start = 1'b1;
                        end else begin
                            state_nx     = S_IDLE;
                            stop_pend_nx = 1'b0;
                            valid_nx     = 1'b0;
                            busy_nx      = 1'b0;
                        end
                    end else if (col == CW'(IMG_W - 1)) begin
                        col_nx = '0;
                        row_nx = row + RW'(1);
                    end else begin
                        col_nx = col + CW'(1);
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        if (frame_start) begin
            col_nx   = '0;
            row_nx   = '0;
            pat_nx   = pattern;
            lfsr_nx  = seed_eff;
            valid_nx = 1'b1;
            busy_nx  = 1'b1;
        end

        if (state_nx == S_RUN) begin
            col_x  = XW'(col_nx);
            row_x  = YW'(row_nx);
            sof_nx = (col_nx == '0) && (row_nx == '0);
            eol_nx = (col_nx == CW'(IMG_W - 1));
            eof_nx = (col_nx == CW'(IMG_W - 1)) && (row_nx == RW'(IMG_H - 1));
            case (pat_nx)
                2'b00:   pixel_nx = col_x[7:0];
                2'b01:   pixel_nx = row_x[7:0];
                2'b10:   pixel_nx = (col_x[2] ^ row_x[2]) ? 8'hFF : 8'h00;
                default: pixel_nx = lfsr_nx;
            endcase
        end else begin
            sof_nx = 1'b0;
            eol_nx = 1'b0;
            eof_nx = 1'b0;
        end
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            col         <= '0;
            row         <= '0;
            lfsr        <= 8'h01;
            pat_r       <= 2'b00;
            stop_pend   <= 1'b0;
            pixel_out   <= 8'h00;
            valid_out   <= 1'b0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
            busy        <= 1'b0;
            frames_done <= 16'h0000;
        end else begin
            state       <= state_nx;
            col         <= col_nx;
            row         <= row_nx;
            lfsr        <= lfsr_nx;
            pat_r       <= pat_nx;
            stop_pend   <= stop_pend_nx;
            pixel_out   <= pixel_nx;
            valid_out   <= valid_nx;
            sof         <= sof_nx;
            eol         <= eol_nx;
            eof         <= eof_nx;
            busy        <= busy_nx;
            frames_done <= frames_nx;
        end
    end

endmodule

// File: tb/tb_pixel_frame_src.sv
// tb/tb_pixel_frame_src.sv - randomized self-checking bench for pixel_frame_src
module tb_pixel_frame_src;

    localparam int W = 32;
    localparam int H = 32;
    localparam int N = W * H;

    logic        clk_in = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cont = 1'b0;
    logic [1:0]  pattern = 2'b00;
    logic [7:0]  seed = 8'h00;
    logic        ready_in = 1'b1;
    logic [7:0]  pixel_out;
    logic        valid_out;
    logic        sof, eol, eof, busy;
    logic [15:0] frames_done;

    int          checks = 0;
    int          errors = 0;
    int          exp_frames = 0;
    logic [1:0]  f_pat [4];
    logic [7:0]  f_seed [4];
    logic [7:0]  cap [4*N];
    int          chg_at = -1;
    logic [1:0]  chg_pat = 2'b00;
    logic [7:0]  chg_seed = 8'h00;
    logic [7:0]  lfsr_exp [6];

    pixel_frame_src #(.IMG_W(W), .IMG_H(H)) dut (
        .clk_in      (clk_in),
        .rstn        (rstn),
        .start       (start),
        .stop        (stop),
        .cont        (cont),
        .pattern     (pattern),
        .seed        (seed),
        .pixel_out   (pixel_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .sof         (sof),
        .eol         (eol),
        .eof         (eof),
        .busy        (busy),
        .frames_done (frames_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        int x;
        int fb;
        x  = int'(v);
        fb = ((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1;
        return 8'(((x << 1) | fb) & 255);
    endfunction

    function automatic logic [7:0] ref_pix(input logic [1:0] pat, input int k, input logic [7:0] lv);
        int c;
        int r;
        c = k % W;
        r = k / W;
        case (pat)
            2'd0:    return 8'(c % 256);
            2'd1:    return 8'(r % 256);
            2'd2:    return ((((c >> 2) ^ (r >> 2)) & 1) != 0) ? 8'hFF : 8'h00;
            default: return lv;
        endcase
    endfunction

    // Called at a negedge; receives up to nframes frames (or limit beats) and scores each beat.
    task automatic rx(input int nframes, input bit rnd, input int limit, input int stop_at);
        int f = 0, k = 0, g = 0, cyc = 0, bub = 0;
        int budget;
        bit hold = 0, stop_done = 0, chg_done = 0;
        logic [7:0] hp = 8'h00;
        logic [2:0] hm = 3'b000;
        logic [7:0] lv;
        budget = nframes * N * 4 + 200;
        lv = (f_seed[0] == 8'h00) ? 8'h01 : f_seed[0];
        while (f < nframes && g < limit && cyc < budget) begin
            if (hold) begin
                check("hold_valid", {31'd0, valid_out}, 32'd1);
                check("hold_pix", {24'd0, pixel_out}, {24'd0, hp});
                check("hold_mark", {29'd0, sof, eol, eof}, {29'd0, hm});
            end
            if (!valid_out) bub++;
            stop = 1'b0;
            if (!stop_done && g == stop_at) begin
                stop = 1'b1;
                stop_done = 1;
            end
            if (!chg_done && g == chg_at) begin
                pattern = chg_pat;
                seed = chg_seed;
                chg_done = 1;
            end
            ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = valid_out && !ready_in;
            hp = pixel_out;
            hm = {sof, eol, eof};
            if (valid_out && ready_in) begin
                check("pix", {24'd0, pixel_out}, {24'd0, ref_pix(f_pat[f], k, lv)});
                check("mark", {29'd0, sof, eol, eof},
                      {29'd0, (k == 0), (k % W == W - 1), (k == N - 1)});
                cap[f*N+k] = pixel_out;
                lv = lfsr_step(lv);
                k++;
                g++;
                if (k == N) begin
                    k = 0;
                    f++;
                    if (f < nframes) lv = (f_seed[f] == 8'h00) ? 8'h01 : f_seed[f];
                end
            end
            @(negedge clk_in);
            cyc++;
        end
        stop = 1'b0;
        ready_in = 1'b1;
        check("beats", g, (limit < nframes * N) ? limit : nframes * N);
        check("bubbles", bub, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        check("start_valid", {31'd0, valid_out}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_frames"}, {16'd0, frames_done}, 32'(exp_frames & 16'hFFFF));
    endtask

    task automatic single(input logic [1:0] pat, input logic [7:0] sd, input bit rnd);
        pattern = pat;
        seed = sd;
        cont = 1'b0;
        f_pat[0] = pat;
        f_seed[0] = sd;
        do_start();
        rx(1, rnd, N, -1);
        exp_frames++;
        end_checks("single");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        lfsr_exp[0] = 8'h01; lfsr_exp[1] = 8'h02; lfsr_exp[2] = 8'h04;
        lfsr_exp[3] = 8'h08; lfsr_exp[4] = 8'h11; lfsr_exp[5] = 8'h23;

        repeat (2) @(negedge clk_in);
        check("rst_pix", {24'd0, pixel_out}, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_mark", {29'd0, sof, eol, eof}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frames", {16'd0, frames_done}, 32'd0);
        rstn = 1'b1;
        @(negedge clk_in);
        check("idle_valid", {31'd0, valid_out}, 32'd0);

        // horizontal ramp, no backpressure
        single(2'd0, 8'h00, 0);
        check("hramp_31", {24'd0, cap[31]}, 32'h1F);
        check("hramp_32", {24'd0, cap[32]}, 32'h00);

        // LFSR with seed 1, then seed 0 which must behave as seed 1
        single(2'd3, 8'h01, 0);
        for (int i = 0; i < 6; i++) check("lfsr_s1", {24'd0, cap[i]}, {24'd0, lfsr_exp[i]});
        single(2'd3, 8'h00, 0);
        for (int i = 0; i < 6; i++) check("lfsr_s0", {24'd0, cap[i]}, {24'd0, lfsr_exp[i]});

        // random backpressure on ramp, then random patterns/seeds
        single(2'd0, 8'h00, 1);
        repeat (2) single(2'($urandom_range(0, 3)), 8'($urandom), 1);

        // continuous: stop mid third frame
        cont = 1'b1;
        pattern = 2'd0;
        for (int i = 0; i < 3; i++) begin f_pat[i] = 2'd0; f_seed[i] = 8'h00; end
        do_start();
        rx(3, 0, 3 * N, 2 * N + 300);
        exp_frames += 3;
        end_checks("cont_stop");

        // continuous: stop on the same edge as the eof beat
        pattern = 2'd1;
        f_pat[0] = 2'd1;
        do_start();
        rx(1, 0, N, N - 1);
        exp_frames++;
        end_checks("stop_eof");

        // stop while idle is ignored; mid-frame pattern/seed change applies next frame
        stop = 1'b1;
        @(negedge clk_in);
        stop = 1'b0;
        @(negedge clk_in);
        pattern = 2'd0;
        seed = 8'h5A;
        f_pat[0] = 2'd0; f_seed[0] = 8'h5A;
        f_pat[1] = 2'd2; f_seed[1] = 8'hC3;
        chg_at = 100; chg_pat = 2'd2; chg_seed = 8'hC3;
        do_start();
        rx(2, 0, 2 * N, N + 50);
        chg_at = -1;
        exp_frames += 2;
        end_checks("chg");
        check("chk_4_0", {24'd0, cap[N+4]}, 32'hFF);
        check("chk_0_4", {24'd0, cap[N+4*W]}, 32'hFF);
        check("chk_4_4", {24'd0, cap[N+4*W+4]}, 32'h00);
        cont = 1'b0;

        // reset mid-frame
        pattern = 2'd0;
        f_pat[0] = 2'd0;
        do_start();
        rx(1, 0, 500, -1);
        rstn = 1'b0;
        #1;
        check("mrst_pix", {24'd0, pixel_out}, 32'd0);
        check("mrst_valid", {31'd0, valid_out}, 32'd0);
        check("mrst_mark", {29'd0, sof, eol, eof}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_frames", {16'd0, frames_done}, 32'd0);
        @(negedge clk_in);
        rstn = 1'b1;
        exp_frames = 0;
        @(negedge clk_in);
        single(2'd0, 8'h00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_frame_src.md
Name: pixel_frame_src

Overview:
Pixel source stage on the clk_in domain that feeds the async-FIFO input of the pixel processing block (pixel_in / valid_in / ready_in).
- Generates raster-ordered frames of IMG_W x IMG_H 8-bit pixels from a selectable test pattern.
- Emits per-pixel framing markers (sof/eol/eof) and counts completed frames.
- Supports single-shot and continuous operation, with graceful stop at a frame boundary.

Parameters:
IMG_W, 32, pixels per line (≥2; matches the downstream 32-entry line buffers)
IMG_H, 32, lines per frame (≥2)

Ports:
clk_in  input  1  pixel clock
rstn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a frame when IDLE
stop  input  1  single-cycle pulse; requests halt at the end of the current frame
cont  input  1  1 = run frames back-to-back; 0 = single frame
pattern  input  2  00 h-ramp, 01 v-ramp, 10 checker, 11 LFSR
seed  input  8  LFSR seed
pixel_out  output  8  pixel data (to downstream pixel_in)
valid_out  output  1  pixel valid (to downstream valid_in)
ready_in  input  1  downstream ready (from downstream ready_in, i.e. FIFO not full)
sof  output  1  qualifies first pixel of frame
eol  output  1  qualifies last pixel of line
eof  output  1  qualifies last pixel of frame
busy  output  1  1 while in RUN
frames_done  output  16  count of completed frames, wraps at 0xFFFF

Behaviour:
- Interface: reset rstn, asynchronous, active-low; single clock clk_in. All outputs are registered.
- Reset values: pixel_out=0, valid_out=0, sof=eol=eof=0, busy=0, frames_done=0. Internal state: col=row=0, lfsr=0x01, stop_pend=0, FSM=IDLE. Reset mid-frame abandons the frame immediately.
- Beat: a transfer occurs on a rising edge where valid_out && ready_in.
  - While valid_out=1 && ready_in=0, pixel_out, sof, eol and eof are held stable.
  - No bubbles: after an accepted beat, the next pixel is presented in the following cycle.
- FSM IDLE:
  - start=1 → RUN in the next cycle with valid_out=1 and pixel (0,0). One-cycle latency from start.
  - On entry, pattern is latched into pat_r.
  - On entry, lfsr is loaded with seed; seed 0x00 is replaced by 0x01.
  - stop pulses in IDLE are ignored.
- FSM RUN:
  - Raster order: col increments per beat. At col=IMG_W-1, col wraps to 0 and row increments.
  - sof=(row==0 && col==0); eol=(col==IMG_W-1); eof=eol && (row==IMG_H-1).
  - start is ignored while in RUN.
  - stop sets stop_pend, which is held until the frame ends. stop on the same edge as the eof beat counts for that frame.
- Frame end (eof beat accepted):
  - frames_done increments.
  - If cont=1 && !stop_pend && !stop: remain in RUN. Present the next frame's pixel (0,0) the next cycle, re-latch pattern, reload lfsr from seed.
  - Otherwise: go to IDLE. valid_out=0 and busy=0 the next cycle; stop_pend clears.
- Patterns, evaluated on the pixel presented:
  - 00 h-ramp: pixel = col[7:0].
  - 01 v-ramp: pixel = row[7:0].
  - 10 checker: pixel = (col[2]^row[2]) ? 8'hFF : 8'h00.
  - 11 LFSR: pixel = lfsr. On each accepted beat, lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The lfsr does not advance on stalled cycles.
- pattern and seed changes mid-frame have no effect until the next frame start.
- Counter widths: col and row use $clog2 of IMG_W and IMG_H. Ramps take the low 8 bits (wrap past 255).

Test Plan:
- Reset, then start, pattern=00, cont=0, ready_in=1 → valid_out rises 1 cycle after start. Pixels 0x00..0x1F on each of 32 lines. eol on every 32nd beat, sof on beat 0, eof on beat 1023. Then valid_out=0, busy=0, frames_done=1.
- pattern=11, seed=0x01, ready_in=1 → first pixels 0x01, 0x02, 0x04, 0x08, 0x11, 0x23. Repeat with seed=0x00 → identical sequence.
- Backpressure: pattern=00, ready_in toggled 1,0,0,1,... → pixel_out/valid_out stable during stalls. No pixel skipped or duplicated; the full 1024-beat sequence is received intact.
- cont=1 for 2 frames, then stop pulse mid-frame 3 → pixel (0,0) follows eof with zero gap. Frame 3 completes fully, then IDLE. frames_done=3.
- Change pattern 00→10 and seed mid-frame → current frame unchanged. The next frame (cont=1) is checker: pixel (4,0)=0xFF, (0,4)=0xFF, (4,4)=0x00.
- Assert rstn low at beat 500 of a frame → all outputs 0 immediately. After release, start restarts at pixel (0,0) with sof=1, frames_done=0.
